// File: rtl/csd_mult_sequencer.sv
// Sequences a general a*b product onto a two-term shift-add multiplier via NAF recoding of b.
// Optional MULT_SEQ_PERF_EN adds a saturating perf_ops count of completed multiplier ops.
module csd_mult_sequencer #(
    parameter int unsigned N   = 4,
    parameter int unsigned A_W = 16,
    localparam int unsigned B_W = (1 << N) - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic [A_W-1:0]     req_a,
    input  logic [B_W-1:0]     req_b,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [A_W+B_W-1:0] rsp_p,
    output logic [A_W-1:0]     mul_a,
    output logic [N-1:0]       mul_b_i,
    output logic [N-1:0]       mul_b_j,
    output logic               mul_one_term,
    output logic               mul_b_sign,
    output logic               mul_vld,
    input  logic [2*A_W-1:0]   mul_c,
`ifdef MULT_SEQ_PERF_EN
    output logic [31:0]        perf_ops,
`endif
    input  logic               mul_result_vld
);

    localparam int unsigned D_W   = B_W + 1;
    localparam int unsigned X_W   = B_W + 2;
    localparam int unsigned P_W   = A_W + B_W;
    localparam int unsigned ACC_W = P_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_RECODE, S_ISSUE, S_GAP, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [A_W-1:0]            a_q, a_d;
    logic [B_W-1:0]            b_q, b_d;
    logic [D_W-1:0]            pos_q, pos_d, neg_q, neg_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      sub_q, sub_d;

    logic                      req_rdy_q, req_rdy_d, rsp_vld_q, rsp_vld_d;
    logic [P_W-1:0]            rsp_p_q, rsp_p_d;
    logic [A_W-1:0]            mul_a_q, mul_a_d;
    logic [N-1:0]              mul_b_i_q, mul_b_i_d, mul_b_j_q, mul_b_j_d;
    logic                      mul_one_term_q, mul_one_term_d, mul_b_sign_q, mul_b_sign_d;
    logic                      mul_vld_q, mul_vld_d;

    function automatic logic [N-1:0] low_idx(input logic [D_W-1:0] v);
        logic [N-1:0] idx;
        idx = '0;
        for (int k = int'(D_W) - 1; k >= 0; k--) begin
            if (v[k]) idx = N'(k);
        end
        return idx;
    endfunction

    // NAF recode: t = 3x, c = t ^ x; digits sit one bit above their weight
    logic [X_W-1:0] x_v, t_v, c_v;
    assign x_v = X_W'(b_q);
    assign t_v = x_v + (x_v << 1);
    assign c_v = t_v ^ x_v;

    // Mask of the (up to) two lowest nonzero digits consumed by the current op
    logic [D_W-1:0] nz_q, rest1_q, rest2_q, clr_q;
    assign nz_q    = pos_q | neg_q;
    assign rest1_q = nz_q & (nz_q - D_W'(1));
    assign rest2_q = rest1_q & (rest1_q - D_W'(1));
    assign clr_q   = nz_q ^ rest2_q;

    logic signed [ACC_W-1:0] c_ext;
    assign c_ext = $signed(ACC_W'(mul_c));

    always_comb begin : next_state
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                if (req_vld && req_rdy_q) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = S_RECODE;
                end
            end
            S_RECODE: begin
                pos_d   = D_W'((t_v & c_v) >> 1);
                neg_d   = D_W'((x_v & c_v) >> 1);
                state_d = (|(pos_d | neg_d)) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (mul_result_vld) begin
                    acc_d   = sub_q ? (acc_q - c_ext) : (acc_q + c_ext);
                    pos_d   = pos_q & ~clr_q;
                    neg_d   = neg_q & ~clr_q;
                    state_d = (|rest2_q) ? S_GAP : S_DONE;
                end
            end
            S_GAP:   state_d = S_ISSUE;
            S_DONE:  if (rsp_rdy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand pick for the op about to be (or still being) issued
    logic [D_W-1:0] nz_d, nzr_d;
    logic [N-1:0]   p_idx, q_idx;
    logic           has_q, p_neg, q_neg;
    assign nz_d  = pos_d | neg_d;
    assign nzr_d = nz_d & (nz_d - D_W'(1));
    assign has_q = |nzr_d;
    assign p_idx = low_idx(nz_d);
    assign q_idx = low_idx(nzr_d);
    assign p_neg = neg_d[p_idx];
    assign q_neg = neg_d[q_idx];

    always_comb begin : out_next
        req_rdy_d      = (state_d == S_IDLE);
        rsp_vld_d      = (state_d == S_DONE);
        rsp_p_d        = rsp_vld_d ? acc_d[P_W-1:0] : '0;
        mul_vld_d      = (state_d == S_ISSUE);
        mul_a_d        = '0;
        mul_b_i_d      = '0;
        mul_b_j_d      = '0;
        mul_one_term_d = 1'b0;
        mul_b_sign_d   = 1'b0;
        sub_d          = 1'b0;
        if (mul_vld_d) begin
            mul_a_d = a_d;
            if (!has_q) begin
                mul_one_term_d = 1'b1;
                mul_b_i_d      = p_idx;
                mul_b_j_d      = p_idx;
                sub_d          = p_neg;
            end else if (p_neg == q_neg) begin
                mul_b_i_d = q_idx;
                mul_b_j_d = p_idx;
                sub_d     = p_neg;
            end else begin
                mul_b_sign_d = 1'b1;
                mul_b_i_d    = p_neg ? q_idx : p_idx;
                mul_b_j_d    = p_neg ? p_idx : q_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            pos_q          <= '0;
            neg_q          <= '0;
            acc_q          <= '0;
            sub_q          <= 1'b0;
            req_rdy_q      <= 1'b1;
            rsp_vld_q      <= 1'b0;
            rsp_p_q        <= '0;
            mul_a_q        <= '0;
            mul_b_i_q      <= '0;
            mul_b_j_q      <= '0;
            mul_one_term_q <= 1'b0;
            mul_b_sign_q   <= 1'b0;
            mul_vld_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            pos_q          <= pos_d;
            neg_q          <= neg_d;
            acc_q          <= acc_d;
            sub_q          <= sub_d;
            req_rdy_q      <= req_rdy_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_p_q        <= rsp_p_d;
            mul_a_q        <= mul_a_d;
            mul_b_i_q      <= mul_b_i_d;
            mul_b_j_q      <= mul_b_j_d;
            mul_one_term_q <= mul_one_term_d;
            mul_b_sign_q   <= mul_b_sign_d;
            mul_vld_q      <= mul_vld_d;
        end
    end

    assign req_rdy      = req_rdy_q;
    assign rsp_vld      = rsp_vld_q;
    assign rsp_p        = rsp_p_q;
    assign mul_a        = mul_a_q;
    assign mul_b_i      = mul_b_i_q;
    assign mul_b_j      = mul_b_j_q;
    assign mul_one_term = mul_one_term_q;
    assign mul_b_sign   = mul_b_sign_q;
    assign mul_vld      = mul_vld_q;

`ifdef MULT_SEQ_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;

    always_comb begin
        perf_ops_d = perf_ops_q;
        if ((state_q == S_ISSUE) && mul_result_vld && (perf_ops_q != '1))
            perf_ops_d = perf_ops_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_ops_q <= '0;
        else        perf_ops_q <= perf_ops_d;
    end

    assign perf_ops = perf_ops_q;
`endif

endmodule

// File: tb/tb_csd_mult_sequencer.sv
// Self-checking bench for csd_mult_sequencer: integer NAF reference, multiplier model, random latency.
module tb_csd_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_rdy;
    logic [15:0] req_a;
    logic [14:0] req_b;
    logic        rsp_vld, rsp_rdy;
    logic [30:0] rsp_p;
    logic [15:0] mul_a;
    logic [3:0]  mul_b_i, mul_b_j;
    logic        mul_one_term, mul_b_sign, mul_vld;
    logic [31:0] mul_c;
    logic        mul_result_vld;
`ifdef MULT_SEQ_PERF_EN
    logic [31:0] perf_ops;
    int          perf_exp = 0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit one;
        int bi;
        int bj;
        bit sg;
    } op_t;
    op_t exp_ops[$];

    csd_mult_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_p(rsp_p),
        .mul_a(mul_a), .mul_b_i(mul_b_i), .mul_b_j(mul_b_j),
        .mul_one_term(mul_one_term), .mul_b_sign(mul_b_sign), .mul_vld(mul_vld),
        .mul_c(mul_c),
`ifdef MULT_SEQ_PERF_EN
        .perf_ops(perf_ops),
`endif
        .mul_result_vld(mul_result_vld)
    );

    always #5 clk = ~clk;

    // Integer NAF of b, then pair consecutive nonzero digits into expected ops
    task automatic build_ops(input int b);
        int n, k, d;
        int dpos[$];
        int dsgn[$];
        op_t o;
        n = b;
        k = 0;
        exp_ops.delete();
        while (n != 0) begin
            if (n % 2 != 0) begin
                d = 2 - (n % 4);
                dpos.push_back(k);
                dsgn.push_back(d);
                n = n - d;
            end
            n = n / 2;
            k++;
        end
        for (int m = 0; m < dpos.size(); m += 2) begin
            if (m + 1 >= dpos.size())    o = '{1'b1, dpos[m], dpos[m], 1'b0};
            else if (dsgn[m] == dsgn[m+1]) o = '{1'b0, dpos[m+1], dpos[m], 1'b0};
            else if (dsgn[m] > 0)        o = '{1'b0, dpos[m], dpos[m+1], 1'b1};
            else                         o = '{1'b0, dpos[m+1], dpos[m], 1'b1};
            exp_ops.push_back(o);
        end
    endtask

    // Drive one request through; act as multiplier and consumer. abort_op>0 resets when that op starts.
    task automatic run_txn(input logic [15:0] a, input logic [14:0] b, input int hold, input int abort_op);
        int          idx, op_n, lat, gap, exp_idx;
        bit          in_op, got;
        logic [15:0] a_s;
        logic [3:0]  bi_s, bj_s;
        bit          one_s, sg_s;
        logic [31:0] av, cv;
        logic [30:0] exp_p;
        build_ops(int'(b));
        exp_p = 31'(longint'(a) * longint'(b));
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++; $display("FAIL idle_req_rdy got %b exp 1", req_rdy);
        end
        req_vld = 1'b1; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_vld = 1'b0; req_a = 16'($urandom); req_b = 15'($urandom);
        checks++;
        if (req_rdy !== 1'b0) begin
            errors++; $display("FAIL busy_req_rdy got %b exp 0", req_rdy);
        end
        idx = 0; op_n = 0; lat = 0; gap = 0; exp_idx = 1; in_op = 0; got = 0;
        a_s = '0; bi_s = '0; bj_s = '0; one_s = 0; sg_s = 0;
        while (!got && idx < 300) begin
            mul_result_vld = 1'b0;
            mul_c = $urandom;
            if (mul_vld === 1'b1) begin
                if (!in_op) begin
                    if (op_n > 0) begin
                        checks++;
                        if (gap != 1) begin
                            errors++; $display("FAIL gap_len got %0d exp 1", gap);
                        end
                    end
                    a_s = mul_a; bi_s = mul_b_i; bj_s = mul_b_j; one_s = mul_one_term; sg_s = mul_b_sign;
                    checks++;
                    if (op_n >= exp_ops.size()) begin
                        errors++; $display("FAIL extra_op got op %0d exp %0d ops", op_n + 1, exp_ops.size());
                    end else if ({a_s, bi_s, bj_s, one_s, sg_s} !==
                                 {a, 4'(exp_ops[op_n].bi), 4'(exp_ops[op_n].bj), exp_ops[op_n].one, exp_ops[op_n].sg}) begin
                        errors++;
                        $display("FAIL op_operands b=%h op %0d got a=%h i=%0d j=%0d one=%b sg=%b exp a=%h i=%0d j=%0d one=%b sg=%b",
                                 b, op_n, a_s, bi_s, bj_s, one_s, sg_s, a, exp_ops[op_n].bi,
                                 exp_ops[op_n].bj, exp_ops[op_n].one, exp_ops[op_n].sg);
                    end
                    in_op = 1;
                    lat = $urandom_range(0, 3);
                    exp_idx += lat + 1 + ((op_n > 0) ? 1 : 0);
                    op_n++;
                    if (abort_op == op_n) begin
                        #2 rst_n = 1'b0;
                        #1;
                        checks++;
                        if ({rsp_vld, rsp_p, mul_a, mul_b_i, mul_b_j, mul_one_term, mul_b_sign, mul_vld} !== '0
                            || req_rdy !== 1'b1) begin
                            errors++;
                            $display("FAIL async_reset got vld=%b p=%h mvld=%b rdy=%b exp zeros rdy=1",
                                     rsp_vld, rsp_p, mul_vld, req_rdy);
                        end
                        @(posedge clk); #1;
                        rst_n = 1'b1;
`ifdef MULT_SEQ_PERF_EN
                        perf_exp = 0;
`endif
                        repeat (6) begin
                            @(posedge clk); #1;
                            checks++;
                            if (rsp_vld !== 1'b0 || mul_vld !== 1'b0 || req_rdy !== 1'b1) begin
                                errors++;
                                $display("FAIL post_abort got rsp_vld=%b mul_vld=%b req_rdy=%b exp 0 0 1",
                                         rsp_vld, mul_vld, req_rdy);
                            end
                        end
                        return;
                    end
                end else begin
                    checks++;
                    if ({mul_a, mul_b_i, mul_b_j, mul_one_term, mul_b_sign} !== {a_s, bi_s, bj_s, one_s, sg_s}) begin
                        errors++; $display("FAIL operand_hold got i=%0d j=%0d exp i=%0d j=%0d", mul_b_i, mul_b_j, bi_s, bj_s);
                    end
                end
                if (lat == 0) begin
                    av = 32'(a_s);
                    if (one_s)     cv = av << bi_s;
                    else if (sg_s) cv = (av << bi_s) - (av << bj_s);
                    else           cv = (av << bi_s) + (av << bj_s);
                    mul_c = cv;
                    mul_result_vld = 1'b1;
                    in_op = 0;
                    gap = 0;
`ifdef MULT_SEQ_PERF_EN
                    perf_exp++;
`endif
                end else begin
                    lat--;
                end
            end else begin
                if (in_op) begin
                    checks++; errors++;
                    $display("FAIL mul_vld_drop got 0 exp 1 (op %0d)", op_n);
                    in_op = 0;
                end
                if (op_n > 0) gap++;
                if ($urandom_range(0, 3) == 0) mul_result_vld = 1'b1;
            end
            if (rsp_vld === 1'b1) begin
                got = 1;
                checks++;
                if (rsp_p !== exp_p) begin
                    errors++; $display("FAIL product a=%h b=%h got %h exp %h", a, b, rsp_p, exp_p);
                end
                checks++;
                if (op_n != exp_ops.size()) begin
                    errors++; $display("FAIL op_count b=%h got %0d exp %0d", b, op_n, exp_ops.size());
                end
                checks++;
                if (idx != exp_idx) begin
                    errors++; $display("FAIL rsp_latency b=%h got %0d exp %0d", b, idx, exp_idx);
                end
            end else begin
                @(posedge clk); #1;
                idx++;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_timeout got no rsp_vld exp rsp within 300 cycles");
        end
        mul_result_vld = 1'b0;
        rsp_rdy = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_vld !== 1'b1 || rsp_p !== exp_p || req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL rsp_hold got vld=%b p=%h rdy=%b exp 1 %h 0", rsp_vld, rsp_p, req_rdy, exp_p);
            end
        end
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        checks++;
        if (rsp_vld !== 1'b0 || req_rdy !== 1'b1) begin
            errors++; $display("FAIL rsp_release got vld=%b rdy=%b exp 0 1", rsp_vld, req_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_vld = 1'b0; req_a = '0; req_b = '0;
        rsp_rdy = 1'b0; mul_c = '0; mul_result_vld = 1'b0;
        #12;
        checks++;
        if ({rsp_vld, rsp_p, mul_a, mul_b_i, mul_b_j, mul_one_term, mul_b_sign, mul_vld} !== '0
            || req_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_state got vld=%b mvld=%b rdy=%b exp 0 0 1", rsp_vld, mul_vld, req_rdy);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_rdy !== 1'b1 || rsp_vld !== 1'b0 || mul_vld !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got rdy=%b vld=%b mvld=%b exp 1 0 0", req_rdy, rsp_vld, mul_vld);
        end
    endtask

    task automatic test_directed();
        run_txn(16'd3, 15'd0, 0, 0);
        run_txn(16'd5, 15'd8, 0, 0);
        run_txn(16'd7, 15'd7, 0, 0);
        run_txn(16'd10, 15'd11, 1, 0);
    endtask

    task automatic test_max_hold();
        run_txn(16'hFFFF, 15'h7FFF, 5, 0);
    endtask

    task automatic test_four_ops_and_abort();
        run_txn(16'd3, 15'h5555, 0, 0);
        run_txn(16'd3, 15'h5555, 0, 2);
        run_txn(16'd2, 15'd3, 0, 0);
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [14:0] b;
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 15'h7FFF;
                2:       b = 15'h2AAA;
                default: b = 15'($urandom);
            endcase
            run_txn(a, b, $urandom_range(0, 2), 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_max_hold();
        test_four_ops_and_abort();
        test_random();
`ifdef MULT_SEQ_PERF_EN
        checks++;
        if (perf_ops !== 32'(perf_exp)) begin
            errors++; $display("FAIL perf_ops got %0d exp %0d", perf_ops, perf_exp);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
